// File: rtl/led_frame_scheduler_if.sv
// Scheduler-side bundle: game refresh request, frame-buffer read port and ws2812b pixel stream.
// master = scheduler, slave = game logic / frame buffer / driver side.
interface led_frame_scheduler_if #(
  parameter int AW = 6
);
  logic          frame_req;
  logic [AW-1:0] fb_addr;
  logic          fb_rd;
  logic [23:0]   fb_data;
  logic [23:0]   pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_latch;
  logic          busy;
  logic          frame_done;

  modport master (
    input  frame_req, fb_data, pix_ready,
    output fb_addr, fb_rd, pix_data, pix_valid, pix_latch, busy, frame_done
  );

  modport slave (
    output frame_req, fb_data, pix_ready,
    input  fb_addr, fb_rd, pix_data, pix_valid, pix_latch, busy, frame_done
  );
endinterface

// File: rtl/led_frame_scheduler.sv
// Streams one ROWSxCOLS frame from the frame buffer to the ws2812b driver, then holds the latch gap.
// Define SERPENTINE_EN to mirror odd rows for a zig-zag wired strip.
module led_frame_scheduler #(
  parameter int ROWS         = 6,
  parameter int COLS         = 7,
  parameter int LATCH_CYCLES = 6000,
  parameter int AW           = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  led_frame_scheduler_if.master bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int LW = $clog2(LATCH_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND, S_LATCH} state_t;

  state_t        state_q;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] colm_d;
  logic [AW-1:0] addr_d;
  logic [LW-1:0] cnt_q;
  logic          pend_q;
  logic          last_px;
  logic [AW-1:0] fb_addr_q;
  logic          fb_rd_q;
  logic [23:0]   pix_data_q;
  logic          pix_valid_q;
  logic          pix_latch_q;
  logic          busy_q;
  logic          frame_done_q;

  // Next pixel position; base_q tracks row*COLS so no multiplier or divider is needed.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q + CW'(1);
    base_d = base_q;
    if (col_q == CW'(COLS - 1)) begin
      col_d  = '0;
      row_d  = row_q + RW'(1);
      base_d = base_q + AW'(COLS);
    end
`ifdef SERPENTINE_EN
    colm_d = row_d[0] ? (CW'(COLS - 1) - col_d) : col_d;
`else
    colm_d = col_d;
`endif
    addr_d  = base_d + AW'(colm_d);
    last_px = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      base_q       <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      fb_addr_q    <= '0;
      fb_rd_q      <= 1'b0;
      pix_data_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_latch_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (bus.frame_req && state_q != S_IDLE) pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (bus.frame_req || pend_q) begin
            pend_q    <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            base_q    <= '0;
            busy_q    <= 1'b1;
            fb_addr_q <= '0;
            fb_rd_q   <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          fb_rd_q <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          pix_data_q  <= bus.fb_data;
          pix_valid_q <= 1'b1;
          state_q     <= S_SEND;
        end
        S_SEND: begin
          if (bus.pix_ready) begin
            pix_valid_q <= 1'b0;
            if (last_px) begin
              pix_latch_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= S_LATCH;
            end else begin
              row_q     <= row_d;
              col_q     <= col_d;
              base_q    <= base_d;
              fb_addr_q <= addr_d;
              fb_rd_q   <= 1'b1;
              state_q   <= S_FETCH;
            end
          end
        end
        S_LATCH: begin
          if (cnt_q == LW'(LATCH_CYCLES - 1)) begin
            pix_latch_q  <= 1'b0;
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + LW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.fb_addr    = fb_addr_q;
  assign bus.fb_rd      = fb_rd_q;
  assign bus.pix_data   = pix_data_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_latch  = pix_latch_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed + randomized-backpressure bench for led_frame_scheduler against a pixel-order reference model.
module tb_led_frame_scheduler;
  localparam int ROWS = 6, COLS = 7, LAT = 4, AW = 6, NPIX = ROWS * COLS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  led_frame_scheduler_if #(.AW(AW)) bus ();

  led_frame_scheduler #(
    .ROWS(ROWS), .COLS(COLS), .LATCH_CYCLES(LAT), .AW(AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Board RAM: word = 0x000100 * address, one cycle read latency.
  always @(posedge clk)
    if (bus.fb_rd) bus.fb_data <= 24'(bus.fb_addr) * 24'h000100;

  // Expected word for the k-th pixel of a frame.
  function automatic logic [23:0] exp_word(input int k);
    int r, c;
    r = k / COLS;
    c = k % COLS;
`ifdef SERPENTINE_EN
    if (r % 2 == 1) c = COLS - 1 - c;
`endif
    return 24'((r * COLS + c) * 256);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_fb_addr", 32'(bus.fb_addr), 0);
    chk("rst_fb_rd", 32'(bus.fb_rd), 0);
    chk("rst_pix_data", 32'(bus.pix_data), 0);
    chk("rst_pix_valid", 32'(bus.pix_valid), 0);
    chk("rst_pix_latch", 32'(bus.pix_latch), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_frame_done", 32'(bus.frame_done), 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_quiet", {28'd0, bus.fb_rd, bus.pix_valid, bus.pix_latch, bus.busy}, 0);
      tick();
    end
  endtask

  // Steps one frame cycle by cycle. Cycle 0 is the frame_req cycle (start=1)
  // or the previous frame_done cycle (start=0).
  task automatic run_frame(input bit start, input bit rnd, input int stall_px,
                           input bit mid_reqs, input bit req_at_done, input int stop_px);
    int cyc, npx, lat, last_acc, first_v;
    bit done, stalled, prev_v, acc, strict;
    logic [23:0] prev_d;
    npx = 0; lat = 0; last_acc = -1; first_v = -1;
    done = 0; stalled = 0; prev_v = 0; prev_d = '0;
    strict = !rnd && stall_px < 0;
    if (start) begin
      bus.frame_req = 1'b1;
      tick();
    end
    cyc = 1;
    while (!done && cyc < 3000) begin
      if (stop_px >= 0 && npx == stop_px) return;
      bus.frame_req = 1'b0;
      if (stall_px >= 0 && !stalled && bus.pix_valid && npx == stall_px) begin
        stalled = 1;
        bus.pix_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
          chk("stall_valid", 32'(bus.pix_valid), 1);
          chk("stall_data", 32'(bus.pix_data), 32'(exp_word(stall_px)));
          tick();
          cyc++;
        end
      end
      bus.pix_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (prev_v) begin
        chk("hold_valid", 32'(bus.pix_valid), 1);
        chk("hold_data", 32'(bus.pix_data), 32'(prev_d));
      end
      if (bus.pix_valid && first_v < 0) begin
        first_v = cyc;
        chk("first_valid_cyc", cyc, 3);
      end
      acc = bus.pix_valid && bus.pix_ready;
      if (acc) begin
        chk("pix_data", 32'(bus.pix_data), 32'(exp_word(npx)));
        if (strict && last_acc >= 0) chk("accept_gap", cyc - last_acc, 3);
        last_acc = cyc;
        npx++;
        if (mid_reqs && (npx == 10 || npx == 20 || npx == 30)) bus.frame_req = 1'b1;
      end
      prev_v = bus.pix_valid && !acc;
      prev_d = bus.pix_data;
      if (bus.pix_latch) lat++;
      if (bus.frame_done) begin
        done = 1;
        chk("frame_npx", npx, NPIX);
        chk("latch_len", lat, LAT);
        chk("busy_at_done", 32'(bus.busy), 0);
        chk("latch_off_at_done", 32'(bus.pix_latch), 0);
        if (req_at_done) bus.frame_req = 1'b1;
      end else begin
        chk("busy_in_frame", 32'(bus.busy), 1);
      end
      tick();
      cyc++;
    end
    bus.frame_req = 1'b0;
    chk("frame_completed", 32'(done), 1);
  endtask

  initial begin
    bus.frame_req = 1'b0;
    bus.pix_ready = 1'b1;
    bus.fb_data   = '0;
    reset = 1'b1;
    tick();
    tick();
    chk_reset_state();
    reset = 1'b0;
    idle_cycles(100);

    // Plain frame, ready tied high: order, latency, spacing, latch length.
    run_frame(1, 0, -1, 0, 0, -1);
    idle_cycles(10);

    // Backpressure at pixel 5.
    run_frame(1, 0, 5, 0, 0, -1);
    idle_cycles(5);

    // Random ready.
    run_frame(1, 1, -1, 0, 0, -1);
    idle_cycles(5);

    // Queueing: 3 mid-frame pulses -> one extra frame; pulse on frame_done -> one more.
    run_frame(1, 1, -1, 1, 0, -1);
    run_frame(0, 1, -1, 0, 1, -1);
    run_frame(0, 0, -1, 0, 0, -1);
    idle_cycles(60);

    // Reset at pixel 20 with a pending request.
    run_frame(1, 1, -1, 1, 0, 20);
    bus.frame_req = 1'b0;
    reset = 1'b1;
    tick();
    chk_reset_state();
    reset = 1'b0;
    bus.pix_ready = 1'b1;
    idle_cycles(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
